// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the packed memory-port reader.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index width: clog2 of depth, but never below 1 so DEPTH=1 still has a port.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_port_reader.sv
// Snapshots a flat DEPTH x WIDTH memory image on start, then streams it word by
// word over valid/ready, lowest index first, with a running modulo checksum.
module mem_port_reader
  import mem_port_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DEPTH*WIDTH-1:0] mem_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   done,
  output logic [WIDTH-1:0]       checksum
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] snap [DEPTH];
  logic             at_last;
  logic             xfer;
  logic             accept;

  assign at_last  = (idx_q == LAST_IDX);
  assign xfer     = out_valid && out_ready;
  assign accept   = (state_q == IDLE) && start;
  assign checksum = sum_q;

  // Word outputs are forced to zero outside STREAM so the unreset snapshot
  // never leaks onto the port.
  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        out_data  = snap[idx_q];
        out_idx   = idx_q;
        out_last  = at_last;
        if (out_ready && at_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Index saturates at the last word; leaving STREAM is what ends the walk,
  // so non-power-of-two depths never index past the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      sum_q <= '0;
    end else if (accept) begin
      idx_q <= '0;
      sum_q <= '0;
    end else if (xfer) begin
      sum_q <= sum_q + out_data;
      if (!at_last) idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < DEPTH; i++) snap[i] <= mem_in[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_mem_port_reader.sv
// Directed bench for mem_port_reader: expected words are queued at start and
// popped as the DUT hands them over; running and final checksums are modelled.
module tb_mem_port_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int IDX_W = 4;
  localparam int IW    = DEPTH * WIDTH;

  logic             clk;
  logic             rst;
  logic             start;
  logic [IW-1:0]    mem_in;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             done;
  logic [WIDTH-1:0] checksum;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t                   sb[$];
  int                     checks = 0;
  int                     errors = 0;
  logic [WIDTH-1:0]       exp_sum;
  logic [WIDTH-1:0]       acc;
  logic                   hold_pending;
  logic [IDX_W+WIDTH-1:0] hold_val;
  logic [IW-1:0]          img_seq, img_wrap, img_ones;
  bit                     dn;

  mem_port_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_in   (mem_in),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .done     (done),
    .checksum (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    hold_pending = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      start     = 1'($urandom);
      out_ready = 1'($urandom);
      for (int w = 0; w < DEPTH; w++) mem_in[w*WIDTH +: WIDTH] = $urandom;
      @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", checksum, 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic start_xfer(input logic [IW-1:0] img);
    exp_t e;
    @(negedge clk);
    start     = 1'b1;
    mem_in    = img;
    out_ready = 1'b0;
    sb.delete();
    exp_sum      = '0;
    acc          = '0;
    hold_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      e.data = img[i*WIDTH +: WIDTH];
      e.idx  = IDX_W'(i);
      e.last = (i == DEPTH - 1);
      sb.push_back(e);
      exp_sum += e.data;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    chk("first_busy", busy, 1);
    chk("sum_restart", checksum, 0);
  endtask

  task automatic cyc(input logic rdy, input logic st, output bit d);
    exp_t e;
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    #1;
    if (hold_pending) chk("stall_hold", {out_valid, out_idx, out_data}, {1'b1, hold_val});
    hold_pending = 1'b0;
    if (out_valid) begin
      chk("run_sum", checksum, acc);
      if (rdy) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("data", out_data, e.data);
          chk("idx", out_idx, e.idx);
          chk("last", out_last, e.last);
          acc += e.data;
        end
      end else begin
        hold_pending = 1'b1;
        hold_val     = {out_idx, out_data};
      end
    end
    d = done;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1,0,1; 2: ready high while
  // mem_in is trashed and start is pulsed in STREAM and DONE
  task automatic drain(input int mode);
    logic [5:0] pat;
    logic       rdy, st;
    int         n;
    bit         got;
    pat = 6'b101001;
    n   = 0;
    got = 0;
    while (!got && n < 100) begin
      n++;
      rdy = (mode == 1) ? pat[(n-1) % 6] : 1'b1;
      st  = (mode == 2) && (n == 2 || n == 5 || n == DEPTH + 1);
      if (mode == 2 && n == 1) mem_in = img_ones;
      cyc(rdy, st, got);
    end
    chk("done_seen", got, 1);
    if (mode == 0) chk("done_latency", n, DEPTH + 1);
    chk("done_no_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    chk("final_sum", checksum, exp_sum);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic idle_check();
    bit d;
    cyc(1'b1, 1'b0, d);
    chk("idle_done", d, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_sum_hold", checksum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; mem_in = '0;
    hold_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      img_seq[i*WIDTH +: WIDTH]  = WIDTH'(i);
      img_wrap[i*WIDTH +: WIDTH] = 32'h8000_0000;
      img_ones[i*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    end

    do_reset(2);

    // in-order stream, ready always high
    start_xfer(img_seq);
    drain(0);
    chk("sum45_a", checksum, 45);
    idle_check();

    // backpressure, then a back-to-back start in the cycle after done
    start_xfer(img_seq);
    drain(1);
    start_xfer(img_seq);
    drain(2);
    chk("sum45_b", checksum, 45);
    idle_check();

    // checksum wraps to zero
    start_xfer(img_wrap);
    drain(0);
    chk("wrap_sum", checksum, 0);

    // reset after word 4 is accepted, then replay from index 0
    start_xfer(img_seq);
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, dn);
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, dn);
      chk("no_done_after_rst", dn, 0);
      chk("idle_after_rst", out_valid, 0);
    end
    start_xfer(img_seq);
    drain(0);
    chk("sum45_c", checksum, 45);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_reader.md
Name: mem_port_reader

Overview:
- Read side of the packed memory-port interface. A writer drives a DEPTH x WIDTH memory image as one flat vector, with word i in bits [i*WIDTH +: WIDTH].
- On a start pulse, this block snapshots that vector into an internal word array. It then streams the words out one at a time over a valid/ready handshake, lowest index first, and reports a running checksum.
- It sits between the memory-image producer and any word-serial consumer.

Parameters:
- WIDTH, 32: bits per memory word.
- DEPTH, 10: number of words in the image. Must be at least 1.
- IDX_W, $clog2(DEPTH) with a minimum of 1: width of the word index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to snapshot mem_in and begin streaming.
- mem_in  input  DEPTH*WIDTH  packed memory image; word i is mem_in[i*WIDTH +: WIDTH].
- busy  output  1  high while a transfer is in progress (STREAM or DONE state).
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  current word.
- out_idx  output  IDX_W  index of the current word.
- out_last  output  1  current word is index DEPTH-1.
- done  output  1  one-cycle pulse after the last word is accepted.
- checksum  output  WIDTH  modulo-2^WIDTH sum of the words accepted so far in this transfer.

Behaviour:
- Reset. Synchronous: rst sampled high at a clock edge sets state=IDLE, idx=0, checksum=0, done=0. All outputs then read 0: busy, out_valid, out_data, out_idx, out_last, done, checksum. The snapshot array is not reset. rst overrides every other input, including during STREAM; the in-flight transfer is abandoned and no done pulse is issued.
- IDLE:
  - out_valid=0.
  - start=1 → copy all DEPTH words of mem_in into the snapshot array, idx<=0, checksum<=0, go to STREAM.
  - start=0 → stay in IDLE.
- STREAM:
  - out_valid=1, out_data=snap[idx], out_idx=idx, out_last=(idx==DEPTH-1).
  - Handshake: a word transfers in a cycle where out_valid and out_ready are both high. On transfer, checksum<=checksum+out_data, with the carry dropped.
  - After a transfer: if out_last, go to DONE; otherwise idx<=idx+1.
  - Without a transfer: out_data, out_idx and out_last hold steady. out_valid never drops while in STREAM.
- DONE:
  - done=1 for exactly this one cycle; out_valid=0.
  - checksum holds the final sum.
  - Next state is always IDLE.
- Latency: first word is valid 1 cycle after start is sampled. With out_ready held high, DEPTH words take DEPTH consecutive cycles, and done asserts on the cycle after the last word.
- start is ignored in STREAM and DONE. Changes on mem_in after the snapshot do not affect the transfer in progress.
- checksum holds its value in IDLE until the next accepted start.
- DEPTH=1: out_last is high on the first word.
- idx never exceeds DEPTH-1, including when DEPTH is not a power of two.
- busy = (state != IDLE).

Decomposition:
- Package mem_port_pkg holds:
  - state enum {IDLE, STREAM, DONE};
  - a function idx_w(depth) returning the minimum-1 clog2.
- No sub-module is needed. The snapshot array plus the index mux are naturally inline. The checksum accumulator is a single register plus adder in the same module.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random inputs → all outputs 0. Release, then start=1 with mem_in = words 0..9 (320'h…09_…08_…_00) and out_ready=1 → out_data is 0,1,…,9 on 10 consecutive cycles; out_idx matches; out_last only with word 9; done pulses on the next cycle; checksum=45.
2. Backpressure: same image; toggle out_ready 1,0,0,1,0,1,… → every word appears once, in order, and out_data is stable while stalled; checksum=45.
3. Snapshot isolation: after start, change mem_in to all 32'hFFFFFFFF, and also pulse start in STREAM → the stream still outputs 0..9 and is not restarted.
4. Wrap of checksum: image of ten words 32'h80000000 → final checksum=0.
5. Reset mid-transfer: assert rst after word 4 is accepted → next cycle out_valid=0, busy=0, checksum=0, no done pulse. A new start replays from index 0.
6. Back-to-back: start sampled in the cycle after done → new transfer, first word valid one cycle later, and checksum restarts from 0.
